cevrilebilir_xor_biriktirici: RTL and testbench
===============================================

CEVRILEBILIR_XOR_BIRIKTIRICI -- requirements
Module: cevrilebilir_xor_biriktirici

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal: >= 1).
REQ-002 Parameter DEPTH, default 4, words per accumulation block (legal: >= 1).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port temizle  input  1  synchronous block abort/clear.
REQ-006 Port mod  input  1  0 = XOR result, 1 = XNOR (bitwise-inverted) result.
REQ-007 Port giris_gecerli  input  1  input word valid.
REQ-008 Port giris_veri  input  WIDTH  input word.
REQ-009 Port giris_hazir  output  1  block can accept an input word.
REQ-010 Port cikis_gecerli  output  1  block result valid.
REQ-011 Port cikis_veri  output  WIDTH  block result.
REQ-012 Port parite  output  1  reduction XOR of cikis_veri.
REQ-013 Port cikis_hazir  input  1  downstream accepts result.

Function
REQ-014 FSM has exactly two states: TOPLA (accumulating) and SUN (presenting result).
REQ-015 In TOPLA: giris_hazir = 1, cikis_gecerli = 0; in SUN: giris_hazir = 0, cikis_gecerli = 1.
REQ-016 Input word accepted on a rising edge where giris_gecerli & giris_hazir & !temizle.
REQ-017 On accept: accumulator <= accumulator XOR giris_veri; word counter increments by 1.
REQ-018 mod is sampled on the first accepted word of a block (counter = 0) and held for that block; later mod changes within the block are ignored.
REQ-019 Accept of word number DEPTH moves FSM to SUN on the same edge; cikis_gecerli is high from the cycle after that edge (latency 1 cycle from last accept).
REQ-020 cikis_veri = accumulator when latched mod = 0, ~accumulator when latched mod = 1; parite = ^cikis_veri.
REQ-021 cikis_veri and parite are 0 whenever cikis_gecerli = 0.
REQ-022 Result handshake: completes on an edge with cikis_gecerli & cikis_hazir; FSM returns to TOPLA, accumulator and counter clear to 0; next word is acceptable in the following cycle.
REQ-023 While cikis_gecerli = 1 and cikis_hazir = 0, cikis_veri and parite hold stable; giris_gecerli is ignored.
REQ-024 temizle = 1 at an edge, in any state: FSM -> TOPLA, accumulator, counter, latched mod -> 0; temizle takes priority over input accept and result handshake on the same edge.
REQ-025 Counter width is clog2(DEPTH+1); counter never exceeds DEPTH.
REQ-026 DEPTH = 1: every accepted word produces a result directly.

Reset
REQ-027 rst = 1 immediately (no clock required): FSM = TOPLA, accumulator = 0, counter = 0, latched mod = 0.
REQ-028 During and after reset: giris_hazir = 1, cikis_gecerli = 0, cikis_veri = 0, parite = 0.
REQ-029 Reset asserted mid-block discards the partial block; no result is produced for it.

Verification (WIDTH = 8, DEPTH = 4)
REQ-030 mod = 0, words 0x0F, 0xF0, 0x55, 0xAA on consecutive cycles, cikis_hazir = 1 -> cikis_gecerli high 1 cycle after 4th accept, cikis_veri = 0x00, parite = 0, then giris_hazir = 1.
REQ-031 mod = 1 at first word, same words, mod toggled to 0 after word 2 -> cikis_veri = 0xFF, parite = 0.
REQ-032 mod = 0, words 0x01, 0x00, 0x00, 0x00, cikis_hazir held 0 for 3 cycles with giris_gecerli = 1 -> cikis_veri = 0x01, parite = 1 stable for all 3 cycles, giris_hazir = 0, no extra word accepted.
REQ-033 Accept 0x12, 0x34, assert rst mid-cycle -> all outputs 0 asynchronously; then words 0x01, 0x02, 0x04, 0x08 -> cikis_veri = 0x0F.
REQ-034 Accept 0xFF, 0xFF, 0xFF, then temizle = 1 together with giris_gecerli = 1 -> word not accepted, counter = 0; next 4 words 0x80, 0x00, 0x00, 0x00 -> cikis_veri = 0x80, parite = 1.
REQ-035 temizle = 1 while in SUN with cikis_hazir = 1 -> FSM TOPLA, cikis_gecerli = 0 next cycle, no handshake counted.

Source files
------------

// File: rtl/cevrilebilir_xor_biriktirici.sv
// Block XOR accumulator: folds DEPTH input words into one result, optionally
// inverted (XNOR), and presents it with a valid/ready handshake and its parity.
module cevrilebilir_xor_biriktirici #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             temizle,
  input  logic             mod,
  input  logic             giris_gecerli,
  input  logic [WIDTH-1:0] giris_veri,
  output logic             giris_hazir,
  output logic             cikis_gecerli,
  output logic [WIDTH-1:0] cikis_veri,
  output logic             parite,
  input  logic             cikis_hazir,
  output logic             durum
);

  // Handshakes: a word moves when giris_gecerli & giris_hazir at a rising edge,
  // a result moves when cikis_gecerli & cikis_hazir; temizle cancels both.
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] SON = CW'(DEPTH - 1);

  typedef enum logic {TOPLA = 1'b0, SUN = 1'b1} durum_t;

  durum_t           st;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    sayac;
  logic             mod_l;
  logic             kabul;
  logic             teslim;

  assign kabul  = giris_gecerli & giris_hazir & ~temizle;
  assign teslim = cikis_gecerli & cikis_hazir & ~temizle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= TOPLA;
      acc   <= '0;
      sayac <= '0;
      mod_l <= 1'b0;
    end else if (temizle) begin
      st    <= TOPLA;
      acc   <= '0;
      sayac <= '0;
      mod_l <= 1'b0;
    end else begin
      case (st)
        TOPLA: begin
          if (kabul) begin
            acc   <= acc ^ giris_veri;
            sayac <= sayac + 1'b1;
            // The block's polarity is fixed by its first word.
            if (sayac == '0) mod_l <= mod;
            if (sayac == SON) st <= SUN;
          end
        end
        SUN: begin
          if (teslim) begin
            st    <= TOPLA;
            acc   <= '0;
            sayac <= '0;
            mod_l <= 1'b0;
          end
        end
        default: st <= TOPLA;
      endcase
    end
  end

  assign giris_hazir   = (st == TOPLA);
  assign cikis_gecerli = (st == SUN);
  assign durum         = st;

  always_comb begin
    cikis_veri = '0;
    if (st == SUN) cikis_veri = mod_l ? ~acc : acc;
  end

  assign parite = ^cikis_veri;

endmodule

// File: tb/tb_cevrilebilir_xor_biriktirici.sv
// Directed bench for the block XOR accumulator: a driver issues words, a
// scoreboard queue holds hand-computed results, a monitor checks each handshake.
module tb_cevrilebilir_xor_biriktirici;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             temizle;
  logic             mod;
  logic             giris_gecerli;
  logic [WIDTH-1:0] giris_veri;
  logic             giris_hazir;
  logic             cikis_gecerli;
  logic [WIDTH-1:0] cikis_veri;
  logic             parite;
  logic             cikis_hazir;
  logic             durum;

  logic [WIDTH:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int handshakes = 0;

  cevrilebilir_xor_biriktirici #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .temizle(temizle), .mod(mod),
    .giris_gecerli(giris_gecerli), .giris_veri(giris_veri),
    .giris_hazir(giris_hazir), .cikis_gecerli(cikis_gecerli),
    .cikis_veri(cikis_veri), .parite(parite), .cikis_hazir(cikis_hazir),
    .durum(durum)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // monitor: a result transfer is visible at the negedge before its edge
  always @(negedge clk) begin
    if (!rst && !temizle && cikis_gecerli && cikis_hazir) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h expected none", {parite, cikis_veri});
      end else begin
        check("result", {parite, cikis_veri}, exp_q.pop_front());
      end
    end
  end

  // driver
  task automatic send(input logic [WIDTH-1:0] d, input logic m);
    int n;
    giris_gecerli = 1'b1;
    giris_veri    = d;
    mod           = m;
    n = 0;
    @(negedge clk);
    while (!giris_hazir && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 9'(giris_hazir), 9'd1);
    @(posedge clk);
    #1;
    giris_gecerli = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; temizle = 1'b0; mod = 1'b0; giris_gecerli = 1'b0;
    giris_veri = '0; cikis_hazir = 1'b1;
    #2;
    check("reset_hazir", 9'(giris_hazir), 9'd1);
    check("reset_gecerli", 9'(cikis_gecerli), 9'd0);
    check("reset_veri", {parite, cikis_veri}, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // words cancel to zero, plain XOR
    exp_q.push_back({1'b0, 8'h00});
    send(8'h0F, 1'b0); send(8'hF0, 1'b0); send(8'h55, 1'b0); send(8'hAA, 1'b0);
    check("t1_latency_gecerli", 9'(cikis_gecerli), 9'd1);
    check("t1_hazir_low", 9'(giris_hazir), 9'd0);
    cycle();
    check("t1_hazir_back", 9'(giris_hazir), 9'd1);
    check("t1_out_cleared", {cikis_gecerli, cikis_veri}, 9'h000);

    // mod latched at the first word, later toggle ignored
    exp_q.push_back({1'b0, 8'hFF});
    send(8'h0F, 1'b1); send(8'hF0, 1'b1); send(8'h55, 1'b0); send(8'hAA, 1'b0);
    check("t2_latency_gecerli", 9'(cikis_gecerli), 9'd1);
    cycle();

    // back-pressure: result holds while input keeps offering a word
    cikis_hazir = 1'b0;
    exp_q.push_back({1'b1, 8'h01});
    send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    giris_gecerli = 1'b1; giris_veri = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_out", {parite, cikis_veri}, {1'b1, 8'h01});
      check("t3_hold_flags", {7'd0, cikis_gecerli, giris_hazir}, 9'b10);
    end
    @(posedge clk); #1;
    giris_gecerli = 1'b0;
    cikis_hazir = 1'b1;
    cycle();

    // asynchronous reset mid-block discards the partial block
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_out", {parite, cikis_veri}, 9'h000);
    check("t4_rst_flags", {7'd0, cikis_gecerli, giris_hazir}, 9'b01);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    exp_q.push_back({1'b0, 8'h0F});
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h04, 1'b0); send(8'h08, 1'b0);
    cycle();

    // temizle beats a simultaneous word
    send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b0);
    temizle = 1'b1; giris_gecerli = 1'b1; giris_veri = 8'h5A;
    cycle();
    temizle = 1'b0; giris_gecerli = 1'b0;
    check("t5_after_clear", {cikis_gecerli, cikis_veri}, 9'h000);
    exp_q.push_back({1'b1, 8'h80});
    send(8'h80, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    check("t5_not_early", 9'(cikis_gecerli), 9'd0);
    send(8'h00, 1'b0);
    check("t5_done", 9'(cikis_gecerli), 9'd1);
    cycle();

    // temizle while a result is offered: no transfer
    cikis_hazir = 1'b0;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h44, 1'b0); send(8'h88, 1'b0);
    check("t6_sun_out", {parite, cikis_veri}, {1'b0, 8'hFF});
    temizle = 1'b1; cikis_hazir = 1'b1;
    cycle();
    temizle = 1'b0;
    check("t6_cleared", {7'd0, cikis_gecerli, giris_hazir}, 9'b01);
    check("t6_out_zero", {parite, cikis_veri}, 9'h000);
    repeat (3) cycle();

    // final report
    check("queue_drained", 9'(exp_q.size()), 9'd0);
    check("handshake_count", 9'(handshakes), 9'd5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
